// File: rtl/line_buf_rd_ctrl.sv
// Line-buffer port-B read controller: walks the pixel stream, reads the
// NUM_TAP-1 previously stored rows and emits one vertical depth column per pixel.
module line_buf_rd_ctrl #(
    parameter int NUM_TAP       = 5,
    parameter int NUM_BANK      = 61,
    parameter int DATA_DEPTH_BW = 16,
    parameter int H_SIZE_BW     = 12,
    parameter int V_SIZE_BW     = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_valid,
    input  logic [DATA_DEPTH_BW-1:0] i_depth1,
    input  logic [H_SIZE_BW-1:0]     r_hsize,
    input  logic [V_SIZE_BW-1:0]     r_vsize,
    input  logic [23:0]              i_lb_sram_QB   [0:NUM_BANK-1],
    output logic [H_SIZE_BW-1:0]     o_lb_sram_AB   [0:NUM_BANK-1],
    output logic                     o_lb_sram_WENB [0:NUM_BANK-1],
    output logic [23:0]              o_lb_sram_DB   [0:NUM_BANK-1],
    output logic                     o_frame_start,
    output logic                     o_frame_end,
    output logic                     o_valid,
    output logic [DATA_DEPTH_BW-1:0] o_depth_col    [0:NUM_TAP-1],
    output logic [NUM_TAP-1:0]       o_tap_vld
);

    localparam int BANK_BW = $clog2(NUM_BANK);

    logic [H_SIZE_BW-1:0]     x;
    logic [V_SIZE_BW-1:0]     y;
    logic [BANK_BW-1:0]       bptr;
    logic                     x_wrap;
    logic                     y_wrap;
    logic                     bptr_last;

    logic [BANK_BW-1:0]       tap_bank [1:NUM_TAP-1];
    logic [NUM_TAP-1:0]       tap_ok;
    logic [H_SIZE_BW-1:0]     ab_d     [0:NUM_BANK-1];

    logic                     vld1, fs1, fe1;
    logic [DATA_DEPTH_BW-1:0] dep1;
    logic [NUM_TAP-1:0]       tv1;
    logic [BANK_BW-1:0]       bank1    [1:NUM_TAP-1];

    logic                     vld2, fs2, fe2;
    logic [DATA_DEPTH_BW-1:0] dep2;
    logic [NUM_TAP-1:0]       tv2;
    logic [BANK_BW-1:0]       bank2    [1:NUM_TAP-1];

    // Port B never writes: the writer owns port A.
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_portb
        assign o_lb_sram_WENB[b] = 1'b1;
        assign o_lb_sram_DB[b]   = '0;
    end

    assign x_wrap    = (x == r_hsize - H_SIZE_BW'(1));
    assign y_wrap    = (y == r_vsize - V_SIZE_BW'(1));
    assign bptr_last = (bptr == BANK_BW'(NUM_BANK - 1));

    // Pixel position and write-bank pointer, tracking the writer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x    <= '0;
            y    <= '0;
            bptr <= '0;
        end else if (i_valid) begin
            if (x_wrap) begin
                x    <= '0;
                y    <= y_wrap ? '0 : y + V_SIZE_BW'(1);
                bptr <= bptr_last ? '0 : bptr + BANK_BW'(1);
            end else begin
                x <= x + H_SIZE_BW'(1);
            end
        end
    end

    // Bank of tap k is bptr-k modulo NUM_BANK, kept non-negative.
    always_comb begin
        for (int k = 1; k < NUM_TAP; k++) begin
            tap_bank[k] = '0;
            if (bptr >= BANK_BW'(k))
                tap_bank[k] = bptr - BANK_BW'(k);
            else
                tap_bank[k] = bptr + BANK_BW'(NUM_BANK - k);
        end
    end

    // Tap k exists only once row y-k is inside the frame.
    always_comb begin
        tap_ok    = '0;
        tap_ok[0] = 1'b1;
        for (int k = 1; k < NUM_TAP; k++)
            tap_ok[k] = (y >= V_SIZE_BW'(k));
    end

    // Next port-B addresses: column x on live tap banks, idle elsewhere.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++)
            ab_d[b] = '1;
        if (i_valid) begin
            for (int k = 1; k < NUM_TAP; k++)
                if (tap_ok[k])
                    ab_d[tap_bank[k]] = x;
        end
    end

    // S1: issue addresses and capture pixel context.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int b = 0; b < NUM_BANK; b++)
                o_lb_sram_AB[b] <= '1;
            vld1 <= 1'b0;
            fs1  <= 1'b0;
            fe1  <= 1'b0;
            dep1 <= '0;
            tv1  <= '0;
            for (int k = 1; k < NUM_TAP; k++)
                bank1[k] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++)
                o_lb_sram_AB[b] <= ab_d[b];
            vld1 <= i_valid;
            fs1  <= i_frame_start;
            fe1  <= i_frame_end;
            dep1 <= i_depth1;
            tv1  <= i_valid ? tap_ok : '0;
            for (int k = 1; k < NUM_TAP; k++)
                bank1[k] <= tap_bank[k];
        end
    end

    // S2: carry context across the SRAM access cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld2 <= 1'b0;
            fs2  <= 1'b0;
            fe2  <= 1'b0;
            dep2 <= '0;
            tv2  <= '0;
            for (int k = 1; k < NUM_TAP; k++)
                bank2[k] <= '0;
        end else begin
            vld2 <= vld1;
            fs2  <= fs1;
            fe2  <= fe1;
            dep2 <= dep1;
            tv2  <= tv1;
            for (int k = 1; k < NUM_TAP; k++)
                bank2[k] <= bank1[k];
        end
    end

    // S3: select read data per tap and register the column.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_tap_vld     <= '0;
            for (int k = 0; k < NUM_TAP; k++)
                o_depth_col[k] <= '0;
        end else begin
            o_valid        <= vld2;
            o_frame_start  <= fs2;
            o_frame_end    <= fe2;
            o_tap_vld      <= tv2;
            o_depth_col[0] <= vld2 ? dep2 : '0;
            for (int k = 1; k < NUM_TAP; k++)
                o_depth_col[k] <= tv2[k] ?
                    i_lb_sram_QB[bank2[k]][DATA_DEPTH_BW-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_line_buf_rd_ctrl.sv
// Testbench for line_buf_rd_ctrl: writer + 1-cycle SRAM model and a
// row-history reference model of the expected depth columns.
module tb_line_buf_rd_ctrl;

    localparam int NT   = 5;
    localparam int NB   = 61;
    localparam int DW   = 16;
    localparam int HW   = 12;
    localparam int VW   = 12;
    localparam int IDLE = (1 << HW) - 1;

    logic          clk;
    logic          rst_n;
    logic          i_frame_start, i_frame_end, i_valid;
    logic [DW-1:0] i_depth1;
    logic [HW-1:0] r_hsize;
    logic [VW-1:0] r_vsize;
    logic [23:0]   qb   [0:NB-1];
    logic [HW-1:0] ab   [0:NB-1];
    logic          wenb [0:NB-1];
    logic [23:0]   db   [0:NB-1];
    logic          o_frame_start, o_frame_end, o_valid;
    logic [DW-1:0] o_depth_col [0:NT-1];
    logic [NT-1:0] o_tap_vld;

    line_buf_rd_ctrl #(
        .NUM_TAP(NT), .NUM_BANK(NB), .DATA_DEPTH_BW(DW),
        .H_SIZE_BW(HW), .V_SIZE_BW(VW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_valid(i_valid), .i_depth1(i_depth1),
        .r_hsize(r_hsize), .r_vsize(r_vsize),
        .i_lb_sram_QB(qb), .o_lb_sram_AB(ab),
        .o_lb_sram_WENB(wenb), .o_lb_sram_DB(db),
        .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
        .o_valid(o_valid), .o_depth_col(o_depth_col), .o_tap_vld(o_tap_vld)
    );

    typedef struct {
        bit       vld, fs, fe;
        bit [4:0] tv;
        int       col [NT];
        int       x, y, pin;
    } exp_t;

    typedef struct {
        int ab [NB];
        int x, pin;
    } abx_t;

    exp_t  exq [$];
    abx_t  abq [$];
    exp_t  ce;
    abx_t  ca;

    int    total = 0;
    int    bad   = 0;
    bit    chk_en = 0;

    int    hs, vs, mx, my, wb;
    int    hist [64][16];

    logic [23:0] mem [0:NB-1][0:15];
    bit          wr_en;
    int          wr_bank, wr_addr;
    logic [23:0] wr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writer on port A and 1-cycle registered read on port B.
    always @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
        for (int b = 0; b < NB; b++)
            qb[b] <= (int'(ab[b]) < 16) ? mem[b][ab[b][3:0]] : 24'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ab(input abx_t a);
        int idx = 0;
        for (int b = NB - 1; b >= 0; b--)
            if (int'(ab[b]) != a.ab[b]) idx = b;
        chk($sformatf("ab[%0d]", idx), int'(ab[idx]), a.ab[idx]);
    endtask

    task automatic chk_portb_tied();
        int nbad = 0;
        for (int b = 0; b < NB; b++)
            if (wenb[b] !== 1'b1 || db[b] !== 24'd0) nbad++;
        chk("portb_tied_bad_banks", nbad, 0);
    endtask

    task automatic chk_zero(input string tag);
        abx_t a;
        for (int b = 0; b < NB; b++) a.ab[b] = IDLE;
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_fs"}, int'(o_frame_start), 0);
        chk({tag, "_fe"}, int'(o_frame_end), 0);
        chk({tag, "_tv"}, int'(o_tap_vld), 0);
        for (int k = 0; k < NT; k++)
            chk($sformatf("%s_col%0d", tag, k), int'(o_depth_col[k]), 0);
        chk_ab(a);
        chk_portb_tied();
    endtask

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            ce = exq.pop_front();
            ca = abq.pop_front();
            chk("o_valid", int'(o_valid), int'(ce.vld));
            chk("o_frame_start", int'(o_frame_start), int'(ce.fs));
            chk("o_frame_end", int'(o_frame_end), int'(ce.fe));
            chk("o_tap_vld", int'(o_tap_vld), int'(ce.tv));
            for (int k = 0; k < NT; k++)
                chk($sformatf("col%0d y=%0d x=%0d", k, ce.y, ce.x),
                    int'(o_depth_col[k]), ce.col[k]);
            chk_ab(ca);
            chk_portb_tied();
            if (ce.pin == 1) begin
                chk("pin1_tv", int'(o_tap_vld), 31);
                chk("pin1_c0", int'(o_depth_col[0]), 82);
                chk("pin1_c1", int'(o_depth_col[1]), 66);
                chk("pin1_c2", int'(o_depth_col[2]), 50);
                chk("pin1_c3", int'(o_depth_col[3]), 34);
                chk("pin1_c4", int'(o_depth_col[4]), 18);
            end
            if (ce.pin == 2) begin
                chk("pin2_tv", int'(o_tap_vld), 3);
                chk("pin2_c1", int'(o_depth_col[1]), ce.x);
                chk("pin2_c2", int'(o_depth_col[2]), 0);
                chk("pin2_c4", int'(o_depth_col[4]), 0);
            end
            if (ce.pin == 3) begin
                chk("pin3_valid", int'(o_valid), 1);
                chk("pin3_tv", int'(o_tap_vld), 1);
            end
            if (ca.pin == 4) begin
                chk("pin4_ab0", int'(ab[0]), ca.x);
                chk("pin4_ab60", int'(ab[60]), ca.x);
                chk("pin4_ab59", int'(ab[59]), ca.x);
                chk("pin4_ab58", int'(ab[58]), ca.x);
                chk("pin4_ab1_idle", int'(ab[1]), IDLE);
            end
        end
    end

    task automatic drive(input bit v, input int dep, input int pin);
        exp_t e;
        abx_t a;
        bit   fs, fe;
        @(posedge clk);
        #2;
        dep = dep & 16'hFFFF;
        fs  = v && mx == 0 && my == 0;
        fe  = v && mx == hs - 1 && my == vs - 1;
        i_valid       = v;
        i_frame_start = fs;
        i_frame_end   = fe;
        i_depth1      = dep[DW-1:0];
        e.vld = v; e.fs = fs; e.fe = fe;
        e.x = mx; e.y = my; e.pin = pin;
        for (int k = 0; k < NT; k++) begin
            e.tv[k] = v && my >= k;
            if (k == 0) e.col[k] = v ? dep : 0;
            else        e.col[k] = e.tv[k] ? hist[my - k][mx] : 0;
        end
        for (int b = 0; b < NB; b++) a.ab[b] = IDLE;
        if (v)
            for (int k = 1; k < NT; k++)
                if (my >= k) a.ab[(wb - k + NB) % NB] = mx;
        a.x = mx; a.pin = pin;
        wr_en   = v;
        wr_bank = wb;
        wr_addr = mx;
        wr_data = {8'($urandom), dep[15:0]};
        if (v) begin
            hist[my][mx] = dep;
            if (mx == hs - 1) begin
                mx = 0;
                wb = (wb + 1) % NB;
                my = (my == vs - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        exq.push_back(e);
        abq.push_back(a);
        chk_en = 1;
    endtask

    task automatic do_reset(input int h, input int v, input bit imm);
        exp_t e;
        abx_t a;
        @(posedge clk);
        #2;
        chk_en        = 0;
        rst_n         = 0;
        i_valid       = 0;
        i_frame_start = 0;
        i_frame_end   = 0;
        wr_en         = 0;
        #1;
        if (imm) chk_zero("rst_imm");
        r_hsize = HW'(h);
        r_vsize = VW'(v);
        hs = h; vs = v; mx = 0; my = 0; wb = 0;
        exq.delete();
        abq.delete();
        e.vld = 0; e.fs = 0; e.fe = 0; e.tv = 0;
        e.x = 0; e.y = 0; e.pin = 0;
        for (int k = 0; k < NT; k++) e.col[k] = 0;
        for (int b = 0; b < NB; b++) a.ab[b] = IDLE;
        a.x = 0; a.pin = 0;
        repeat (3) exq.push_back(e);
        abq.push_back(a);
        repeat (2) @(posedge clk);
        #3;
        chk_zero("rst_hold");
        rst_n = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        i_valid = 0; i_frame_start = 0; i_frame_end = 0; i_depth1 = '0;
        r_hsize = HW'(4); r_vsize = VW'(6);
        wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = '0;
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < 16; j++) mem[b][j] = 24'($urandom);
        do_reset(4, 6, 0);

        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 4; x++)
                drive(1, 16 * y + x, (y == 5 && x == 2) ? 1 : (y == 1 ? 2 : 0));

        drive(1, 16 * my + mx, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(1, 16 * my + mx, 0);
        drive(1, 16 * my + mx, 0);
        drive(0, 0, 0);
        drive(1, 16 * my + mx, 0);
        drive(1, 16 * my + mx, 0);

        do_reset(4, 6, 1);
        drive(1, 123, 3);
        for (int i = 0; i < 6; i++) drive(1, int'($urandom), 0);

        do_reset(4, 64, 1);
        for (int n = 0; n < 260; ) begin
            bit v = ($urandom % 4) != 0;
            drive(v, int'($urandom), (v && wb == 1 && my >= 4) ? 4 : 0);
            if (v) n++;
        end

        do_reset(7, 9, 0);
        for (int n = 0; n < 189; ) begin
            bit v = ($urandom % 3) != 0;
            drive(v, int'($urandom), 0);
            if (v) n++;
        end

        repeat (4) drive(0, 0, 0);
        @(posedge clk);
        #2;
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
